// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver with a 2-flop input synchroniser,
// false-start rejection, parity/framing error reporting and a valid/ack
// output handshake with overrun detection.
//
// Optional build macro: UART_RX_MAJORITY_VOTE_EN
//   When defined, every bit decision is the 2-of-3 majority of rx_s sampled
//   at baud counter values 1, 0 and CLK_DIV-1. The decision is made one
//   cycle after the centre sample.
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   uart_rx      in   serial line, idle high, asynchronous to clk
//   rx_data      out  received word, held while rx_valid=1
//   rx_valid     out  word available; stays high until accepted
//   rx_ack       in   consumer accepts the word when rx_valid & rx_ack
//   frame_err    out  qualifies rx_data: a stop bit was sampled low
//   parity_err   out  qualifies rx_data: parity mismatch
//   overrun_err  out  one-cycle pulse: frame completed while previous word unaccepted
//   rx_busy      out  high in any state other than IDLE
module uart_rx_cfg #(
    parameter int unsigned CLK_DIV    = 10416,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ack,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output logic                 rx_busy
);

    localparam int unsigned      CNT_W    = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLK_DIV - 1) / 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Synchroniser
    logic r_sync1;
    logic r_sync2;
    logic w_rx_s;

    // Receive state
    state_t               r_state,       w_state_nxt;
    logic [CNT_W-1:0]     r_cnt,         w_cnt_nxt;
    logic [3:0]           r_bit_idx,     w_bit_idx_nxt;
    logic                 r_stop_idx,    w_stop_idx_nxt;
    logic [DATA_BITS-1:0] r_shift,       w_shift_nxt;
    logic                 r_frame_flag,  w_frame_flag_nxt;
    logic                 r_parity_flag, w_parity_flag_nxt;
    logic                 r_done,        w_done_nxt;
    logic                 r_need_idle,   w_need_idle_nxt;

    // Output holding registers
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_frame_err;
    logic                 r_parity_err;
    logic                 r_overrun;

    // Bit decision strobe and decided bit value
    logic w_tick;
    logic w_bit;

    assign w_rx_s = r_sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= uart_rx;
            r_sync2 <= r_sync1;
        end
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic r_vote0;
    logic r_vote1;
    logic r_vote_pend;

    // The third vote is rx_s itself on the cycle after the counter wraps,
    // so the decision strobe is a registered copy of the wrap condition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vote0     <= 1'b1;
            r_vote1     <= 1'b1;
            r_vote_pend <= 1'b0;
        end else begin
            if (r_cnt == CNT_W'(1)) begin
                r_vote0 <= w_rx_s;
            end
            if (r_cnt == '0) begin
                r_vote1 <= w_rx_s;
            end
            r_vote_pend <= (r_state != S_IDLE) && (r_cnt == '0);
        end
    end

    assign w_tick = r_vote_pend;
    assign w_bit  = (r_vote0 & r_vote1) | (r_vote0 & w_rx_s) | (r_vote1 & w_rx_s);
`else
    assign w_tick = (r_state != S_IDLE) && (r_cnt == '0);
    assign w_bit  = w_rx_s;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_bit_idx     <= '0;
            r_stop_idx    <= 1'b0;
            r_shift       <= '0;
            r_frame_flag  <= 1'b0;
            r_parity_flag <= 1'b0;
            r_done        <= 1'b0;
            r_need_idle   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_bit_idx     <= w_bit_idx_nxt;
            r_stop_idx    <= w_stop_idx_nxt;
            r_shift       <= w_shift_nxt;
            r_frame_flag  <= w_frame_flag_nxt;
            r_parity_flag <= w_parity_flag_nxt;
            r_done        <= w_done_nxt;
            r_need_idle   <= w_need_idle_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_bit_idx_nxt     = r_bit_idx;
        w_stop_idx_nxt    = r_stop_idx;
        w_shift_nxt       = r_shift;
        w_frame_flag_nxt  = r_frame_flag;
        w_parity_flag_nxt = r_parity_flag;
        w_done_nxt        = 1'b0;
        w_need_idle_nxt   = r_need_idle;

        // Baud counter free-runs while a frame is in progress
        if (r_state != S_IDLE) begin
            w_cnt_nxt = (r_cnt == '0) ? CNT_FULL : r_cnt - 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (w_rx_s) begin
                    w_need_idle_nxt = 1'b0;
                end else if (!r_need_idle) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = CNT_HALF;
                end
            end
            S_START: begin
                if (w_tick) begin
                    if (w_bit) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt       = S_DATA;
                        w_bit_idx_nxt     = '0;
                        w_frame_flag_nxt  = 1'b0;
                        w_parity_flag_nxt = 1'b0;
                    end
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_shift_nxt = {w_bit, r_shift[DATA_BITS-1:1]};
                    if (r_bit_idx == 4'(DATA_BITS - 1)) begin
                        w_state_nxt    = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        w_stop_idx_nxt = 1'b0;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (w_tick) begin
                    w_parity_flag_nxt = (w_bit != ((^r_shift) ^ 1'(PARITY_ODD)));
                    w_state_nxt       = S_STOP;
                    w_stop_idx_nxt    = 1'b0;
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    if (!w_bit) begin
                        w_frame_flag_nxt = 1'b1;
                    end
                    if (r_stop_idx == 1'(STOP_BITS - 1)) begin
                        w_state_nxt     = S_IDLE;
                        w_done_nxt      = 1'b1;
                        // A low final stop bit (e.g. a break) must see the
                        // line return high before another start is accepted.
                        w_need_idle_nxt = !w_bit;
                    end else begin
                        w_stop_idx_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Completion and handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_done) begin
                if (!r_rx_valid || rx_ack) begin
                    r_rx_data    <= r_shift;
                    r_frame_err  <= r_frame_flag;
                    r_parity_err <= r_parity_flag;
                    r_rx_valid   <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_rx_valid && rx_ack) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign frame_err   = r_frame_err;
    assign parity_err  = r_parity_err;
    assign overrun_err = r_overrun;
    assign rx_busy     = (r_state != S_IDLE);

endmodule
